regfile_write_master: RTL
=========================

// Module: regfile_write_master
// PURPOSE
// - Writer side of the register-file write port. Collects writeback results from the ALU
//   path and the memory-load path and feeds them to the register file one per cycle.
// - Buffers the results in a small in-order FIFO and drives writeRpoint/writeData/writeEnable.
// - Reports to the decode stage which source registers have a write still outstanding.
// PARAMETERS
// - DATA_W  8  width of a register value
// - ADDR_W  5  register index width (32 registers)
// - DEPTH   4  FIFO entries; power of two, >=2
// PORTS
// - clk           in   1       clock; all state updates on posedge
// - rst_n         in   1       asynchronous, active-low reset
// - memValid      in   1       load result valid
// - memRd         in   ADDR_W  load destination register
// - memData       in   DATA_W  load value
// - memReady      out  1       load result accepted when memValid&&memReady
// - aluValid      in   1       ALU result valid
// - aluRd         in   ADDR_W  ALU destination register
// - aluData       in   DATA_W  ALU value
// - aluReady      out  1       ALU result accepted when aluValid&&aluReady
// - writeRpoint   out  ADDR_W  to register file: write index
// - writeData     out  DATA_W  to register file: write value
// - writeEnable   out  1       to register file: sampled on negedge clk
// - R1point       in   ADDR_W  decode source 1 index
// - R2point       in   ADDR_W  decode source 2 index
// - r1Pending     out  1       write to R1point outstanding (comb.)
// - r2Pending     out  1       write to R2point outstanding (comb.)
// - r1Fwd, r2Fwd  out  DATA_W  youngest pending value (only with WB_BYPASS_EN, else 0)
// BEHAVIOUR
// - Reset (async, rst_n=0): FIFO empty, count=0. writeEnable=0, writeRpoint=0, writeData=0.
//   memReady=1, aluReady=1. Pending/Fwd outputs are 0. An in-flight write is dropped.
// - Readiness comes from the registered count only (no same-cycle drain credit):
//   memReady = (count<=DEPTH-1); aluReady = (count<=DEPTH-2).
// - Enqueue at posedge. If both sources fire in one cycle, the mem entry is written first
//   (older), then the alu entry. Up to 2 pushes per cycle.
// - A write with Rd==0 is accepted (the handshake completes) but is not enqueued.
// - Drain: at each posedge where the FIFO is non-empty, the head is popped into the output
//   registers and writeEnable=1 for the next cycle. Otherwise writeEnable=0.
//   Output regs hold their last index/data when idle.
// - Latency: an entry accepted at edge k into an empty FIFO pops at edge k+1.
//   writeEnable is high in cycle k+1..k+2, and the register file writes at the negedge inside it.
// - Simultaneous push and pop: count_next = count + pushes - pop, where pushes is 0..2.
//   The count never exceeds DEPTH because of the ready rules. Pointers wrap mod DEPTH.
// - Ordering: strictly FIFO. The same Rd queued twice produces two writes, in order.
// - Pending: rXPending=1 if any valid FIFO entry has rd==RXpoint, or if writeEnable=1 and
//   writeRpoint==RXpoint (the write is not committed until negedge). Always 0 for index 0.
// - No internal state machine besides FIFO pointers/count and the output stage.
//   Pending logic is combinational.
// CONFIGURATION
// - WB_BYPASS_EN defined: rXFwd = data of the youngest pending match. Search order is
//   alu/mem push in the current cycle is excluded, then FIFO tail..head, then the output stage.
//   Value is 0 when there is no match.
// - WB_BYPASS_EN undefined: rXFwd tied to 0; decode must stall on rXPending.
// TESTING
// - Reset mid-traffic: fill 3 entries, pulse rst_n low between edges -> writeEnable=0
//   immediately, count=0, both ready=1, no write seen afterwards.
// - Single ALU write rd=5 data=0x2A at edge k -> writeEnable=1, writeRpoint=5,
//   writeData=0x2A in cycle k+1..k+2 only. r1Pending=1 for R1point=5 from k until the write cycle ends.
// - Same-cycle mem rd=3/0x11 and alu rd=3/0x22 -> two consecutive writes, 0x11 then 0x22.
//   With WB_BYPASS_EN, r1Fwd=0x22 while both are pending, then 0x22 again.
// - Fill: DEPTH=4 with no drain possible (continuous pushes) -> aluReady drops at count=3,
//   memReady drops at count=4. No entry is lost or overwritten. Drain order matches push order.
// - rd=0 write with data 0xFF -> handshake completes, writeEnable stays 0, r1Pending=0 for R1point=0.
// - Pointer wrap: 10 back-to-back single pushes -> 10 writes in order, count returns to 0,
//   writeEnable=0 after the last.

Source files
------------

// File: rtl/regfile_write_master.sv
// regfile_write_master
// Writer side of the register-file write port. ALU and memory-load writeback
// results are queued in a small in-order FIFO and retired one per cycle into
// the register file through a registered output stage. The decode stage is
// told which of its two source registers still has a write outstanding.
//
// Optional feature (macro WB_BYPASS_EN): when defined, r1Fwd/r2Fwd carry the
// value of the youngest outstanding write to the requested register. When
// undefined they are tied to zero and decode must stall on r1Pending/r2Pending.

module regfile_write_master #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              memValid,
  input  logic [ADDR_W-1:0] memRd,
  input  logic [DATA_W-1:0] memData,
  output logic              memReady,
  input  logic              aluValid,
  input  logic [ADDR_W-1:0] aluRd,
  input  logic [DATA_W-1:0] aluData,
  output logic              aluReady,
  output logic [ADDR_W-1:0] writeRpoint,
  output logic [DATA_W-1:0] writeData,
  output logic              writeEnable,
  input  logic [ADDR_W-1:0] R1point,
  input  logic [ADDR_W-1:0] R2point,
  output logic              r1Pending,
  output logic              r2Pending,
  output logic [DATA_W-1:0] r1Fwd,
  output logic [DATA_W-1:0] r2Fwd
);

  // DEPTH is a power of two, so the count needs exactly one bit more than a pointer.
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1'b1);
  localparam logic [PTR_W-1:0]  PTR_ZERO  = PTR_W'(1'b0);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0]  CNT_ZERO  = CNT_W'(1'b0);
  localparam logic [CNT_W-1:0]  MEM_LIMIT = CNT_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  ALU_LIMIT = CNT_W'(DEPTH - 2);
  localparam logic [ADDR_W-1:0] RD_ZERO   = {ADDR_W{1'b0}};
  localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

  // FIFO storage and bookkeeping
  logic [ADDR_W-1:0] fifo_rd_r   [DEPTH];
  logic [DATA_W-1:0] fifo_data_r [DEPTH];
  logic [PTR_W-1:0]  head_r;
  logic [PTR_W-1:0]  tail_r;
  logic [CNT_W-1:0]  count_r;

  // Registered handshake and output stage
  logic              mem_ready_r;
  logic              alu_ready_r;
  logic              write_en_r;
  logic [ADDR_W-1:0] write_rd_r;
  logic [DATA_W-1:0] write_data_r;

  // Next-state helpers
  logic              mem_push_s;
  logic              alu_push_s;
  logic              pop_s;
  logic [1:0]        push_cnt_s;
  logic [PTR_W-1:0]  alu_slot_s;
  logic [PTR_W-1:0]  tail_next_s;
  logic [PTR_W-1:0]  head_next_s;
  logic [CNT_W-1:0]  count_next_s;

  // Pending / forwarding helpers
  logic [DEPTH-1:0]  slot_valid_s;
  logic              r1_pend_s;
  logic              r2_pend_s;

  // Push/pop decisions; rd==0 results complete the handshake but are discarded.
  always_comb begin
    mem_push_s = memValid && mem_ready_r && (memRd != RD_ZERO);
    alu_push_s = aluValid && alu_ready_r && (aluRd != RD_ZERO);
    pop_s      = (count_r != CNT_ZERO);
    push_cnt_s = {1'b0, mem_push_s} + {1'b0, alu_push_s};
    if (mem_push_s) begin
      alu_slot_s = tail_r + PTR_ONE;
    end else begin
      alu_slot_s = tail_r;
    end
    tail_next_s = tail_r + PTR_W'(push_cnt_s);
    if (pop_s) begin
      head_next_s  = head_r + PTR_ONE;
      count_next_s = count_r + CNT_W'(push_cnt_s) - CNT_ONE;
    end else begin
      head_next_s  = head_r;
      count_next_s = count_r + CNT_W'(push_cnt_s);
    end
  end

  // FIFO entry storage: the mem result lands first (older), the ALU result behind it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_rd_r[i]   <= RD_ZERO;
        fifo_data_r[i] <= DATA_ZERO;
      end
    end else begin
      if (mem_push_s) begin
        fifo_rd_r[tail_r]   <= memRd;
        fifo_data_r[tail_r] <= memData;
      end
      if (alu_push_s) begin
        fifo_rd_r[alu_slot_s]   <= aluRd;
        fifo_data_r[alu_slot_s] <= aluData;
      end
    end
  end

  // Pointers, occupancy, and readiness derived from the occupancy that will be registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_r      <= PTR_ZERO;
      tail_r      <= PTR_ZERO;
      count_r     <= CNT_ZERO;
      mem_ready_r <= 1'b1;
      alu_ready_r <= 1'b1;
    end else begin
      head_r      <= head_next_s;
      tail_r      <= tail_next_s;
      count_r     <= count_next_s;
      mem_ready_r <= (count_next_s <= MEM_LIMIT);
      alu_ready_r <= (count_next_s <= ALU_LIMIT);
    end
  end

  // Output stage: pop the head into the write registers; hold index/data when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_en_r   <= 1'b0;
      write_rd_r   <= RD_ZERO;
      write_data_r <= DATA_ZERO;
    end else if (pop_s) begin
      write_en_r   <= 1'b1;
      write_rd_r   <= fifo_rd_r[head_r];
      write_data_r <= fifo_data_r[head_r];
    end else begin
      write_en_r   <= 1'b0;
      write_rd_r   <= write_rd_r;
      write_data_r <= write_data_r;
    end
  end

  // Mark which FIFO slots hold live entries (distance from head below the count).
  always_comb begin
    slot_valid_s = {DEPTH{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      slot_valid_s[i] = ({1'b0, PTR_W'(i) - head_r} < count_r);
    end
  end

  // Outstanding-write detection for both decode sources; register 0 is never pending.
  always_comb begin
    r1_pend_s = write_en_r && (write_rd_r == R1point);
    r2_pend_s = write_en_r && (write_rd_r == R2point);
    for (int i = 0; i < DEPTH; i++) begin
      if (slot_valid_s[i] && (fifo_rd_r[i] == R1point)) begin
        r1_pend_s = 1'b1;
      end else begin
        r1_pend_s = r1_pend_s;
      end
      if (slot_valid_s[i] && (fifo_rd_r[i] == R2point)) begin
        r2_pend_s = 1'b1;
      end else begin
        r2_pend_s = r2_pend_s;
      end
    end
    if (R1point == RD_ZERO) begin
      r1_pend_s = 1'b0;
    end else begin
      r1_pend_s = r1_pend_s;
    end
    if (R2point == RD_ZERO) begin
      r2_pend_s = 1'b0;
    end else begin
      r2_pend_s = r2_pend_s;
    end
  end

`ifdef WB_BYPASS_EN
  logic [DATA_W-1:0] r1_fwd_s;
  logic [DATA_W-1:0] r2_fwd_s;
  logic [PTR_W-1:0]  age_slot_s;

  // Youngest-match forwarding: output stage is oldest, then FIFO head..tail; later hits override.
  always_comb begin
    r1_fwd_s   = DATA_ZERO;
    r2_fwd_s   = DATA_ZERO;
    age_slot_s = head_r;
    if (write_en_r && (write_rd_r == R1point)) begin
      r1_fwd_s = write_data_r;
    end else begin
      r1_fwd_s = DATA_ZERO;
    end
    if (write_en_r && (write_rd_r == R2point)) begin
      r2_fwd_s = write_data_r;
    end else begin
      r2_fwd_s = DATA_ZERO;
    end
    for (int j = 0; j < DEPTH; j++) begin
      age_slot_s = head_r + PTR_W'(j);
      if (({1'b0, PTR_W'(j)} < count_r) && (fifo_rd_r[age_slot_s] == R1point)) begin
        r1_fwd_s = fifo_data_r[age_slot_s];
      end else begin
        r1_fwd_s = r1_fwd_s;
      end
      if (({1'b0, PTR_W'(j)} < count_r) && (fifo_rd_r[age_slot_s] == R2point)) begin
        r2_fwd_s = fifo_data_r[age_slot_s];
      end else begin
        r2_fwd_s = r2_fwd_s;
      end
    end
    if (R1point == RD_ZERO) begin
      r1_fwd_s = DATA_ZERO;
    end else begin
      r1_fwd_s = r1_fwd_s;
    end
    if (R2point == RD_ZERO) begin
      r2_fwd_s = DATA_ZERO;
    end else begin
      r2_fwd_s = r2_fwd_s;
    end
  end

  assign r1Fwd = r1_fwd_s;
  assign r2Fwd = r2_fwd_s;
`else
  assign r1Fwd = DATA_ZERO;
  assign r2Fwd = DATA_ZERO;
`endif

  assign memReady    = mem_ready_r;
  assign aluReady    = alu_ready_r;
  assign writeEnable = write_en_r;
  assign writeRpoint = write_rd_r;
  assign writeData   = write_data_r;
  assign r1Pending   = r1_pend_s;
  assign r2Pending   = r2_pend_s;

endmodule
